// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multicycle control unit: fetch/exec/writeback sequencing and control-word decode
//
// Ports:
//   clk      in   system clock, all state updates on posedge
//   rstn     in   asynchronous active-high reset (1 = reset)
//   stall    in   freezes state, pc and ir; forces RW and mem_we low
//   ins      in   [15:0] instruction word at address pc, sampled in FETCH
//   psw      in   [3:0] datapath flags {V, C, N, Z}
//   cw       out  [12:0] control word {TD, TA, TB, MB, FS[4:0], MD, RW, MM, 0}
//   DA/AA/BA out  [2:0] register addresses from ir
//   pc       out  [8:0] program counter
//   mem_we   out  data-memory write strobe
//   halted   out  high while in HALT
//   illegal  out  high in EXEC of an undefined instruction class
module cpu_ctrl #(
    parameter logic [8:0] RESET_PC = 9'd0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic [15:0] ins,
    input  logic [3:0]  psw,
    output logic [12:0] cw,
    output logic [2:0]  DA,
    output logic [2:0]  AA,
    output logic [2:0]  BA,
    output logic [8:0]  pc,
    output logic        mem_we,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic [8:0]  r_pc;
    logic [8:0]  w_pc_next;

    logic [3:0]  w_cls;
    logic [2:0]  w_sub;
    logic [4:0]  w_fs;
    logic        w_mb;
    logic        w_md;
    logic        w_rw;
    logic        w_mm;
    logic        w_we;
    logic        w_ill;
    logic        w_taken;

    assign w_cls = r_ir[15:12];
    assign w_sub = r_ir[2:0];

    // Branch condition: selected flag must equal the inverted polarity bit.
    assign w_taken = (psw[r_ir[10:9]] == ~r_ir[11]);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
        end else if (!stall) begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (r_state == S_FETCH) begin
                r_ir <= ins;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        w_fs      = 5'd0;
        w_mb      = 1'b0;
        w_md      = 1'b0;
        w_rw      = 1'b0;
        w_mm      = 1'b0;
        w_we      = 1'b0;
        w_ill     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mm      = 1'b1;
                w_pc_next = r_pc + 9'd1;
                w_next    = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_cls)
                    4'd0: ;
                    4'd1: begin
                        w_fs = {2'b00, w_sub};
                        w_rw = 1'b1;
                    end
                    4'd2: begin
                        w_fs = {2'b01, w_sub};
                        w_rw = 1'b1;
                    end
                    4'd3: begin
                        // BA field is used as a small constant operand.
                        w_fs = {2'b00, w_sub};
                        w_mb = 1'b1;
                        w_rw = 1'b1;
                    end
                    4'd4: w_next = S_WB;
                    4'd5: w_we = 1'b1;
                    4'd6: begin
                        // pc already points past the branch; offset is relative to that.
                        if (w_taken) begin
                            w_pc_next = r_pc + {{3{r_ir[5]}}, r_ir[5:0]};
                        end
                    end
                    4'd7:  w_pc_next = r_ir[8:0];
                    4'd15: w_next = S_HALT;
                    default: w_ill = 1'b1;
                endcase
            end
            S_WB: begin
                w_md   = 1'b1;
                w_rw   = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Register-file and memory writes are suppressed while stalled so a held
    // EXEC/WB cycle cannot commit twice.
    assign cw      = {3'b000, w_mb, w_fs, w_md, w_rw & ~stall, w_mm, 1'b0};
    assign mem_we  = w_we & ~stall;
    assign DA      = r_ir[11:9];
    assign AA      = r_ir[8:6];
    assign BA      = r_ir[5:3];
    assign pc      = r_pc;
    assign halted  = (r_state == S_HALT);
    assign illegal = w_ill;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - self-checking bench for cpu_ctrl with instruction-level reference model
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic [15:0] ins;
    logic [3:0]  psw;
    logic [12:0] cw;
    logic [2:0]  DA, AA, BA;
    logic [8:0]  pc;
    logic        mem_we, halted, illegal;

    logic [15:0] imem [512];
    assign ins = imem[pc];

    cpu_ctrl #(.RESET_PC(9'd0)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .ins(ins), .psw(psw),
        .cw(cw), .DA(DA), .AA(AA), .BA(BA), .pc(pc),
        .mem_we(mem_we), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: which phase of the current instruction we are in,
    // the instruction being executed and the architectural pc.
    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_WB    = 2;
    localparam int PH_HALT  = 3;

    int          m_phase = PH_FETCH;
    int          m_pc    = 0;
    logic [15:0] m_ir    = 16'h0000;

    always @(posedge clk or posedge rstn) begin
        int cls, off;
        if (rstn) begin
            m_phase = PH_FETCH;
            m_pc    = 0;
            m_ir    = 16'h0000;
        end else if (!stall) begin
            cls = int'(m_ir[15:12]);
            if (m_phase == PH_FETCH) begin
                m_ir    = imem[m_pc];
                m_pc    = (m_pc + 1) % 512;
                m_phase = PH_EXEC;
            end else if (m_phase == PH_EXEC) begin
                m_phase = PH_FETCH;
                if (cls == 4) m_phase = PH_WB;
                if (cls == 15) m_phase = PH_HALT;
                if (cls == 7) m_pc = int'(m_ir[8:0]);
                if (cls == 6 && (psw[m_ir[10:9]] != m_ir[11])) begin
                    off = int'(m_ir[5:0]);
                    if (off >= 32) off = off - 64;
                    m_pc = (m_pc + off + 512) % 512;
                end
            end else if (m_phase == PH_WB) begin
                m_phase = PH_FETCH;
            end
        end
    end

    always @(negedge clk) begin
        int cls, sub, fs, mb, md, rw, we, ill, e_cw;
        if (chk_en) begin
            cls = int'(m_ir[15:12]);
            sub = int'(m_ir[2:0]);
            fs = 0; mb = 0; md = 0; rw = 0; we = 0; ill = 0;
            e_cw = 0;
            if (m_phase == PH_FETCH) begin
                e_cw = 2;
            end else if (m_phase == PH_EXEC) begin
                if (cls == 1) begin fs = sub; rw = 1; end
                if (cls == 2) begin fs = 8 + sub; rw = 1; end
                if (cls == 3) begin fs = sub; mb = 1; rw = 1; end
                if (cls == 5) we = 1;
                if (cls >= 8 && cls <= 14) ill = 1;
                if (stall) begin rw = 0; we = 0; end
                e_cw = mb * 512 + fs * 16 + rw * 4;
            end else if (m_phase == PH_WB) begin
                md = 1;
                rw = stall ? 0 : 1;
                e_cw = md * 8 + rw * 4;
            end
            chk("cw", int'(cw), e_cw);
            chk("pc", int'(pc), m_pc);
            chk("mem_we", int'(mem_we), we);
            chk("illegal", int'(illegal), ill);
            chk("halted", int'(halted), (m_phase == PH_HALT) ? 1 : 0);
            chk("DA", int'(DA), int'(m_ir[11:9]));
            chk("AA", int'(AA), int'(m_ir[8:6]));
            chk("BA", int'(BA), int'(m_ir[5:3]));
        end
    end

    // Assert reset between clock edges, check it takes hold immediately,
    // then release on a falling edge so the next rising edge is the first FETCH.
    task automatic hit_reset();
        #1 rstn = 1'b1;
        #1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_cw", int'(cw), 13'h002);
        chk("rst_halted", int'(halted), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_illegal", int'(illegal), 0);
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 512; i++) imem[i] = 16'h0000;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pulses;
        rstn  = 1'b1;
        stall = 1'b0;
        psw   = 4'b0000;
        clear_imem();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;

        // ALU, LD and misc classes
        imem[0] = 16'h1A53;
        imem[1] = 16'h44C0;
        imem[2] = 16'h2A5F;
        imem[3] = 16'h3B17;
        hit_reset();
        cyc(1);
        chk("alu_exec_cw", int'(cw), 13'h034);
        chk("alu_DA", int'(DA), 5);
        chk("alu_AA", int'(AA), 1);
        chk("alu_BA", int'(BA), 2);
        chk("alu_pc", int'(pc), 1);
        cyc(1);
        chk("alu_back_fetch", int'(cw), 13'h002);
        cyc(1);
        chk("ld_exec_cw", int'(cw), 13'h000);
        chk("ld_DA", int'(DA), 2);
        chk("ld_AA", int'(AA), 3);
        cyc(1);
        chk("ld_wb_cw", int'(cw), 13'h00C);
        cyc(1);
        chk("ld_back_fetch", int'(cw), 13'h002);
        chk("ld_pc", int'(pc), 2);
        cyc(8);

        // Reset landing in LD writeback
        clear_imem();
        imem[0] = 16'h44C0;
        hit_reset();
        cyc(2);
        chk("ldwb_pre_cw", int'(cw), 13'h00C);
        hit_reset();
        cyc(3);

        // Branch taken / not taken, jump, pc wrap
        clear_imem();
        imem[0]  = 16'h700A;
        imem[10] = 16'h603E;
        imem[11] = 16'h71FF;
        psw = 4'b0001;
        hit_reset();
        cyc(2);
        chk("jmp10_pc", int'(pc), 10);
        cyc(1);
        chk("br_exec_pc", int'(pc), 11);
        cyc(1);
        chk("br_taken_pc", int'(pc), 9);
        cyc(2);
        chk("br_refetch_pc", int'(pc), 10);
        psw = 4'b0000;
        cyc(2);
        chk("br_not_taken_pc", int'(pc), 11);
        cyc(2);
        chk("jmp511_pc", int'(pc), 511);
        cyc(1);
        chk("wrap_pc", int'(pc), 0);
        cyc(4);

        // Store held in EXEC by stall
        clear_imem();
        imem[0] = 16'h5000;
        hit_reset();
        @(posedge clk);
        #1 stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("st_we_stalled", int'(mem_we), 0);
            chk("st_pc_stalled", int'(pc), 1);
        end
        #1 stall = 1'b0;
        #1 chk("st_we_released", int'(mem_we), 1);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(mem_we);
        end
        chk("st_extra_pulses", pulses, 0);

        // Illegal class then HALT
        clear_imem();
        imem[0] = 16'h8000;
        imem[1] = 16'hF000;
        hit_reset();
        cyc(1);
        chk("ill_pulse", int'(illegal), 1);
        chk("ill_pc", int'(pc), 1);
        cyc(1);
        chk("ill_cleared", int'(illegal), 0);
        chk("ill_pc_fetch", int'(pc), 1);
        cyc(2);
        chk("halt_flag", int'(halted), 1);
        chk("halt_cw", int'(cw), 0);
        cyc(12);
        chk("halt_pc_frozen", int'(pc), 2);
        chk("halt_still", int'(halted), 1);
        hit_reset();
        cyc(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
